// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the parity-protected serial link.
// The transmitter side uses the same state and parity-mode encodings.
package serial_parity_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Error when data XOR parity does not equal the expected parity mode.
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic par_bit,
                                           input logic mode);
    return (data_xor ^ par_bit) != mode;
  endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Bundle of the serial receive inputs and the decoded-frame outputs.
// sin_valid qualifies sin; there is no backpressure, every qualified bit is consumed.
interface serial_parity_checker_if #(
  parameter int DATA_W = 3,
  parameter int CNT_W  = 8
);
  import serial_parity_checker_pkg::*;

  logic              frame_start;
  logic              sin;
  logic              sin_valid;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              frame_done;
  logic              parity_err;
  logic [CNT_W-1:0]  err_count;
  state_t            dbg_state;

  modport master (
    output frame_start, sin, sin_valid,
    input  busy, data_out, frame_done, parity_err, err_count, dbg_state
  );

  modport slave (
    input  frame_start, sin, sin_valid,
    output busy, data_out, frame_done, parity_err, err_count, dbg_state
  );

endinterface

// File: rtl/serial_parity_acc.sv
// Frame accumulator: places serial bits LSB first and keeps their running XOR.
module serial_parity_acc #(
  parameter int DATA_W = 3,
  localparam int BIT_W = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [BIT_W-1:0]  idx,
  input  logic              din,
  output logic [DATA_W-1:0] data,
  output logic              xor_acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data    <= '0;
      xor_acc <= 1'b0;
    end else if (clr) begin
      data    <= '0;
      xor_acc <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (idx == BIT_W'(i)) data[i] <= din;
      end
      xor_acc <= xor_acc ^ din;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Serial parity receiver: reassembles DATA_W-bit frames, checks the trailing
// parity bit and counts bad frames with a saturating counter.
module serial_parity_checker
  import serial_parity_checker_pkg::*;
#(
  parameter int DATA_W     = 3,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  serial_parity_checker_if.slave bus
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic PAR_MODE = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

  state_t            state, state_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              acc_clr, acc_en, done_nxt, frame_bad;
  logic [DATA_W-1:0] acc_data;
  logic              acc_xor;
  logic [DATA_W-1:0] data_q;
  logic              done_q, err_q;
  logic [CNT_W-1:0]  cnt_q;

  serial_parity_acc #(.DATA_W(DATA_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (acc_clr),
    .en      (acc_en),
    .idx     (bit_cnt),
    .din     (bus.sin),
    .data    (acc_data),
    .xor_acc (acc_xor)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.frame_start) begin
          state_nxt = ST_DATA;
          acc_clr   = 1'b1;
        end
      end
      ST_DATA: begin
        if (bus.sin_valid) begin
          acc_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_nxt = ST_PAR;
        end
      end
      ST_PAR: begin
        if (bus.sin_valid) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign frame_bad = parity_mismatch(acc_xor, bus.sin, PAR_MODE);

  // Bit counter tops out at DATA_W, so it never wraps inside a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          bit_cnt <= '0;
    else if (acc_clr) bit_cnt <= '0;
    else if (acc_en)  bit_cnt <= bit_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= done_nxt;
      if (done_nxt) begin
        data_q <= acc_data;
        err_q  <= frame_bad;
        if (frame_bad && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.busy       = (state == ST_DATA) || (state == ST_PAR);
  assign bus.data_out   = data_q;
  assign bus.frame_done = done_q;
  assign bus.parity_err = err_q;
  assign bus.err_count  = cnt_q;
  assign bus.dbg_state  = state;

endmodule
